// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: first-word-fall-through byte buffer with parity flag,
// sticky overrun, fill-level and idle-timeout interrupt.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TO_BITS    = 40
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_EN,
  input  logic                  RX_PERR,
  input  logic [15:0]           BIT_TIME,
  input  logic                  RD,
  input  logic                  FLUSH,
  input  logic                  OVR_CLR,
  input  logic [DEPTH_LOG2:0]   THRESHOLD,
  output logic [7:0]            RD_DATA,
  output logic                  RD_PERR,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  OVERRUN,
  output logic                  TIMEOUT,
  output logic                  IRQ
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TO_BITS + 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [TW-1:0]       TO_MAX   = TW'(TO_BITS);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [TW-1:0]         BIT_ONE = TW'(1);

  logic [8:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  ovr_q, ovr_d;
  logic [15:0]           pre_q, pre_d;
  logic [TW-1:0]         bit_q, bit_d;
  logic                  empty, full;
  logic                  push, pop, drop, tick;
  logic [8:0]            head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);

  // A full FIFO still accepts a byte when the same cycle frees a slot.
  assign push = RX_EN & (~full | RD) & ~FLUSH;
  assign pop  = RD & ~empty & ~FLUSH;
  assign drop = RX_EN & full & ~RD & ~FLUSH;
  assign tick = (pre_q >= BIT_TIME);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
    pre_d  = pre_q;
    bit_d  = bit_q;
    if (FLUSH) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
      if (push & ~pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop & ~push) cnt_d = cnt_q - CNT_ONE;
    end
    if (drop)         ovr_d = 1'b1;
    else if (OVR_CLR) ovr_d = 1'b0;
    if (FLUSH | push | pop | empty) begin
      pre_d = '0;
      bit_d = '0;
    end else if (tick) begin
      pre_d = '0;
      if (bit_q != TO_MAX) bit_d = bit_q + BIT_ONE;
    end else begin
      pre_d = pre_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      pre_q  <= '0;
      bit_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
      pre_q  <= pre_d;
      bit_q  <= bit_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {RX_PERR, RX_DATA};
  end

  assign head    = mem_q[rptr_q];
  assign RD_DATA = empty ? 8'h00 : head[7:0];
  assign RD_PERR = empty ? 1'b0 : head[8];
  assign EMPTY   = empty;
  assign FULL    = full;
  assign COUNT   = cnt_q;
  assign OVERRUN = ovr_q;
  assign TIMEOUT = (bit_q == TO_MAX) & ~empty;
  assign IRQ     = ((THRESHOLD != '0) & (cnt_q >= THRESHOLD)) | TIMEOUT;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
  localparam int TOB   = 40;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        RX_EN = 1'b0;
  logic        RX_PERR = 1'b0;
  logic [15:0] BIT_TIME = 16'd9;
  logic        RD = 1'b0;
  logic        FLUSH = 1'b0;
  logic        OVR_CLR = 1'b0;
  logic [DL:0] THRESHOLD = '0;
  logic [7:0]  RD_DATA;
  logic        RD_PERR;
  logic        EMPTY;
  logic        FULL;
  logic [DL:0] COUNT;
  logic        OVERRUN;
  logic        TIMEOUT;
  logic        IRQ;

  uart_rx_fifo #(.DEPTH_LOG2(DL), .TO_BITS(TOB)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .RX_DATA(RX_DATA), .RX_EN(RX_EN), .RX_PERR(RX_PERR),
    .BIT_TIME(BIT_TIME), .RD(RD), .FLUSH(FLUSH),
    .OVR_CLR(OVR_CLR), .THRESHOLD(THRESHOLD),
    .RD_DATA(RD_DATA), .RD_PERR(RD_PERR),
    .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
    .OVERRUN(OVERRUN), .TIMEOUT(TIMEOUT), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  logic [8:0] mq[$];
  bit         m_ovr;
  int         m_idle;
  int         n_tests;
  int         n_fail;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    int    sz;
    bit    e_to;
    bit    e_irq;
    logic [8:0] hd;
    sz   = mq.size();
    hd   = (sz != 0) ? mq[0] : 9'h000;
    e_to = (sz != 0) && (m_idle >= TOB * (int'(BIT_TIME) + 1));
    e_irq = ((THRESHOLD != 0) && (sz >= int'(THRESHOLD))) || e_to;
    chk("count", 32'(COUNT), 32'(sz));
    chk("empty", 32'(EMPTY), 32'(sz == 0));
    chk("full", 32'(FULL), 32'(sz == DEPTH));
    chk("rd_data", 32'(RD_DATA), 32'(hd[7:0]));
    chk("rd_perr", 32'(RD_PERR), 32'(hd[8]));
    chk("overrun", 32'(OVERRUN), 32'(m_ovr));
    chk("timeout", 32'(TIMEOUT), 32'(e_to));
    chk("irq", 32'(IRQ), 32'(e_irq));
  endtask

  task automatic model_update();
    bit full, empty, push, pop;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    if (!RESET_N) begin
      mq.delete();
      m_ovr  = 0;
      m_idle = 0;
    end else if (FLUSH) begin
      mq.delete();
      m_idle = 0;
      if (OVR_CLR) m_ovr = 0;
    end else begin
      push = RX_EN && (!full || RD);
      pop  = RD && !empty;
      if (RX_EN && full && !RD) m_ovr = 1;
      else if (OVR_CLR)         m_ovr = 0;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({RX_PERR, RX_DATA});
      if (push || pop || empty) m_idle = 0;
      else                      m_idle++;
    end
  endtask

  task automatic step();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic quiet();
    RX_EN = 0; RD = 0; FLUSH = 0; OVR_CLR = 0;
  endtask

  task automatic push_b(input logic [7:0] d, input logic p);
    RX_DATA = d; RX_PERR = p; RX_EN = 1;
    step();
    quiet();
  endtask

  task automatic pop_b();
    RD = 1;
    step();
    quiet();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_ovr   = 0;
    m_idle  = 0;
    repeat (2) step();
    RESET_N = 1;
    step();
    chk("rst_empty", 32'(EMPTY), 32'd1);
    chk("rst_count", 32'(COUNT), 32'd0);

    push_b(8'hA5, 0);
    push_b(8'h3C, 1);
    chk("t1_count", 32'(COUNT), 32'd2);
    chk("t1_head", 32'({RD_PERR, RD_DATA}), 32'h0A5);
    pop_b();
    chk("t1_second", 32'({RD_PERR, RD_DATA}), 32'h13C);
    pop_b();
    chk("t1_empty", 32'(EMPTY), 32'd1);

    for (int i = 0; i <= 16; i++) push_b(8'(i), 0);
    chk("t2_full", 32'(FULL), 32'd1);
    chk("t2_ovr", 32'(OVERRUN), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_order", 32'(RD_DATA), 32'(i));
      pop_b();
    end
    chk("t2_drained", 32'(EMPTY), 32'd1);
    OVR_CLR = 1;
    step();
    quiet();
    chk("t2_ovr_clr", 32'(OVERRUN), 32'd0);

    for (int i = 0; i < 16; i++) push_b(8'h40 + 8'(i), 0);
    RX_DATA = 8'h99; RX_PERR = 1; RX_EN = 1; RD = 1;
    step();
    quiet();
    chk("t3_count", 32'(COUNT), 32'd16);
    chk("t3_no_ovr", 32'(OVERRUN), 32'd0);
    for (int i = 0; i < 15; i++) pop_b();
    chk("t3_last", 32'({RD_PERR, RD_DATA}), 32'h199);
    pop_b();
    RX_DATA = 8'h5A; RX_PERR = 0; RX_EN = 1; RD = 1;
    step();
    quiet();
    chk("t3_empty_rw", 32'(COUNT), 32'd1);
    chk("t3_kept", 32'(RD_DATA), 32'h5A);
    pop_b();

    THRESHOLD = 4;
    for (int i = 0; i < 3; i++) push_b(8'(i), 0);
    chk("t4_irq3", 32'(IRQ), 32'd0);
    push_b(8'h03, 0);
    chk("t4_irq4", 32'(IRQ), 32'd1);
    pop_b();
    chk("t4_irq_rd", 32'(IRQ), 32'd0);
    THRESHOLD = 0;
    for (int i = 0; i < 13; i++) push_b(8'(i), 0);
    chk("t4_full", 32'(FULL), 32'd1);
    chk("t4_thr0", 32'(IRQ), 32'd0);
    FLUSH = 1;
    step();
    quiet();

    BIT_TIME = 9;
    push_b(8'h77, 0);
    repeat (399) step();
    chk("t5_to_early", 32'(TIMEOUT), 32'd0);
    step();
    chk("t5_to", 32'(TIMEOUT), 32'd1);
    chk("t5_irq", 32'(IRQ), 32'd1);
    pop_b();
    chk("t5_to_clr", 32'(TIMEOUT), 32'd0);
    repeat (1000) step();
    chk("t5_empty_idle", 32'(TIMEOUT), 32'd0);

    for (int i = 0; i < 17; i++) push_b(8'(i), 0);
    FLUSH = 1;
    step();
    quiet();
    for (int i = 0; i < 5; i++) push_b(8'hC0 + 8'(i), 1);
    FLUSH = 1; RX_EN = 1; RX_DATA = 8'hEE;
    step();
    quiet();
    chk("t6_count", 32'(COUNT), 32'd0);
    chk("t6_empty", 32'(EMPTY), 32'd1);
    chk("t6_ovr", 32'(OVERRUN), 32'd1);
    for (int i = 0; i < 3; i++) push_b(8'h10 + 8'(i), 0);
    THRESHOLD = 2;
    @(posedge CLK);
    #2 RESET_N = 0;
    #1;
    chk("rst_async_cnt", 32'(COUNT), 32'd0);
    chk("rst_async_empty", 32'(EMPTY), 32'd1);
    chk("rst_async_data", 32'(RD_DATA), 32'd0);
    chk("rst_async_ovr", 32'(OVERRUN), 32'd0);
    chk("rst_async_irq", 32'(IRQ), 32'd0);
    mq.delete();
    m_ovr  = 0;
    m_idle = 0;
    step();
    RESET_N = 1;
    step();

    for (int blk = 0; blk < 20; blk++) begin
      bit busy;
      busy      = ($urandom_range(0, 1) == 1);
      BIT_TIME  = 16'($urandom_range(0, 2));
      THRESHOLD = 5'($urandom_range(0, 16));
      FLUSH = 1;
      step();
      quiet();
      for (int c = 0; c < 200; c++) begin
        int pe, pr;
        pe = busy ? 45 : 3;
        pr = busy ? 35 : 2;
        RX_DATA = 8'($urandom);
        RX_PERR = 1'($urandom);
        RX_EN   = ($urandom_range(0, 99) < pe);
        RD      = ($urandom_range(0, 99) < pr);
        FLUSH   = ($urandom_range(0, 199) == 0);
        OVR_CLR = !FLUSH && ($urandom_range(0, 49) == 0);
        step();
      end
      quiet();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
